// File: rtl/psum_router_seq_if.sv
// Command, monitor and router-control bundle for one psum router sequencer.
// The master side is the layer controller plus the router's monitored output.
interface psum_router_seq_if #(
  parameter int LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_in_sel;
  logic             cmd_out_sel;
  logic [LEN_W-1:0] cmd_len;
  logic             abort;
  logic             mon_valid;
  logic             mon_ready;
  logic             data_in_sel;
  logic             data_out_sel;
  logic             route_en;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [LEN_W-1:0] beat_cnt;

  modport master (
    output cmd_valid, cmd_in_sel, cmd_out_sel, cmd_len, abort, mon_valid, mon_ready,
    input  cmd_ready, data_in_sel, data_out_sel, route_en, busy, done, aborted, beat_cnt
  );

  modport slave (
    input  cmd_valid, cmd_in_sel, cmd_out_sel, cmd_len, abort, mon_valid, mon_ready,
    output cmd_ready, data_in_sel, data_out_sel, route_en, busy, done, aborted, beat_cnt
  );
endinterface

// File: rtl/psum_router_seq.sv
// Psum router sequencer: latches mux selects from a queued command and opens the
// route only while the selects are stable, counting beats until length or abort.
//
// state | meaning
// IDLE  | waiting for a command, selects hold their last value
// SETUP | new selects settling at the router, traffic gated off
// RUN   | route_en high, counting beats on the selected output
// DONE  | one-cycle completion pulse, then back to IDLE
module psum_router_seq #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  psum_router_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic             in_sel_q, in_sel_d;
  logic             out_sel_q, out_sel_d;
  logic             aborted_q, aborted_d;
  logic             route_en;
  logic             beat;
  logic             last_beat;

  assign route_en  = (state_q == S_RUN);
  assign beat      = route_en & bus.mon_valid & bus.mon_ready;
  assign cnt_inc   = cnt_q + LEN_W'(1);
  assign last_beat = beat & (cnt_inc == len_q);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    in_sel_d  = in_sel_q;
    out_sel_d = out_sel_q;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          in_sel_d  = bus.cmd_in_sel;
          out_sel_d = bus.cmd_out_sel;
          len_d     = bus.cmd_len;
          cnt_d     = '0;
          aborted_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = (len_q == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (beat) begin
          cnt_d = cnt_inc;
        end
        // A final beat coinciding with abort still counts as normal completion.
        if (last_beat) begin
          aborted_d = 1'b0;
          state_d   = S_DONE;
        end else if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      in_sel_q  <= 1'b0;
      out_sel_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      in_sel_q  <= in_sel_d;
      out_sel_q <= out_sel_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.cmd_ready    = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.aborted      = (state_q == S_DONE) & aborted_q;
  assign bus.route_en     = route_en;
  assign bus.data_in_sel  = in_sel_q;
  assign bus.data_out_sel = out_sel_q;
  assign bus.beat_cnt     = cnt_q;

endmodule

// File: tb/tb_psum_router_seq.sv
// Self-checking bench for psum_router_seq: vector table, directed corner sequences,
// and randomized commands checked against a cycle-timeline reference model.
module tb_psum_router_seq;
  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_router_seq_if #(.LEN_W(LEN_W)) bus ();
  psum_router_seq #(.LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        cv;
    logic        is;
    logic        os;
    logic [15:0] len;
    logic        ab;
    logic        mv;
    logic        mr;
    logic [22:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Packed view: {cmd_ready, busy, route_en, done, aborted, in_sel, out_sel, beat_cnt}
  function automatic logic [22:0] e(input logic rdy, input logic bsy, input logic ren,
                                    input logic dn, input logic ab, input logic is,
                                    input logic os, input logic [15:0] cnt);
    return {rdy, bsy, ren, dn, ab, is, os, cnt};
  endfunction

  function automatic vec_t v(input logic cv, input logic is, input logic os,
                             input logic [15:0] len, input logic ab, input logic mv,
                             input logic mr, input logic [22:0] exp);
    vec_t r;
    r.cv = cv; r.is = is; r.os = os; r.len = len;
    r.ab = ab; r.mv = mv; r.mr = mr; r.exp = exp;
    return r;
  endfunction

  task automatic drive(input logic cv, input logic is, input logic os, input logic [15:0] len,
                       input logic ab, input logic mv, input logic mr);
    bus.cmd_valid   = cv;
    bus.cmd_in_sel  = is;
    bus.cmd_out_sel = os;
    bus.cmd_len     = len;
    bus.abort       = ab;
    bus.mon_valid   = mv;
    bus.mon_ready   = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [22:0] exp);
    logic [22:0] a;
    a = {bus.cmd_ready, bus.busy, bus.route_en, bus.done, bus.aborted,
         bus.data_in_sel, bus.data_out_sel, bus.beat_cnt};
    n_vec++;
    if (a !== exp) begin
      n_bad++;
      $display("FAIL %s: got rdy/busy/ren/done/abt/in/out=%b cnt=%0d, want %b cnt=%0d",
               name, a[22:16], a[15:0], exp[22:16], exp[15:0]);
    end
  endtask

  initial begin
    logic [15:0] m_cnt, rlen;
    logic        m_in, m_out, m_ab, fin, mv, mr, ab;
    int          ap, c;
    logic        mr_pat [5];

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("reset", e(1, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    tick();
    chk("idle_after_reset", e(1, 0, 0, 0, 0, 0, 0, 0));

    // len=4 streaming, len=0 config-only, len=8 aborted after 2 beats
    tbl.push_back(v(1, 1, 1, 4, 0, 0, 0, e(0, 1, 0, 0, 0, 1, 1, 0)));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, e(0, 1, 1, 0, 0, 1, 1, 0)));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, e(0, 1, 1, 0, 0, 1, 1, 1)));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, e(0, 1, 1, 0, 0, 1, 1, 2)));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, e(0, 1, 1, 0, 0, 1, 1, 3)));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, e(0, 1, 0, 1, 0, 1, 1, 4)));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, e(1, 0, 0, 0, 0, 1, 1, 4)));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, e(0, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, e(0, 1, 0, 1, 0, 0, 0, 0)));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 1, 0, 8, 0, 0, 0, e(0, 1, 0, 0, 0, 1, 0, 0)));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, e(0, 1, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, e(0, 1, 1, 0, 0, 1, 0, 1)));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, e(0, 1, 1, 0, 0, 1, 0, 2)));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, e(0, 1, 0, 1, 1, 1, 0, 2)));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, e(1, 0, 0, 0, 0, 1, 0, 2)));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, e(1, 0, 0, 0, 0, 1, 0, 2)));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].cv, tbl[i].is, tbl[i].os, tbl[i].len, tbl[i].ab, tbl[i].mv, tbl[i].mr);
      tick();
      chk($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // len=3 with mon_ready toggling: only the ready cycles count
    drive(1, 1, 1, 3, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("toggle_run", e(0, 1, 1, 0, 0, 1, 1, 0));
    mr_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, mr_pat[i]); tick();
      chk($sformatf("toggle%0d", i), e(0, 1, 1, 0, 0, 1, 1, 16'((i + 2) / 2)));
    end
    drive(0, 0, 0, 0, 0, 1, mr_pat[4]); tick();
    chk("toggle_done", e(0, 1, 0, 1, 0, 1, 1, 3));
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("toggle_idle", e(1, 0, 0, 0, 0, 1, 1, 3));

    // abort coincident with the final beat: completion wins
    drive(1, 1, 1, 8, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 0, 0, 1, 1); tick();
      chk($sformatf("len8_beat%0d", i + 1), e(0, 1, 1, 0, 0, 1, 1, 16'(i + 1)));
    end
    drive(0, 0, 0, 0, 1, 1, 1); tick();
    chk("abort_on_last", e(0, 1, 0, 1, 0, 1, 1, 8));
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("abort_on_last_idle", e(1, 0, 0, 0, 0, 1, 1, 8));

    // abort with a non-final beat: beat counted and aborted flagged
    drive(1, 0, 1, 3, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 1, 1); tick();
    chk("abort_with_beat", e(0, 1, 0, 1, 1, 0, 1, 1));
    drive(0, 0, 0, 0, 0, 0, 0); tick();

    // cmd_valid held across two commands: second taken only once back in IDLE
    drive(1, 1, 1, 1, 0, 0, 0); tick();
    chk("hold_a_setup", e(0, 1, 0, 0, 0, 1, 1, 0));
    drive(1, 0, 0, 1, 0, 1, 1); tick();
    chk("hold_a_run", e(0, 1, 1, 0, 0, 1, 1, 0));
    tick();
    chk("hold_a_done", e(0, 1, 0, 1, 0, 1, 1, 1));
    tick();
    chk("hold_gap_idle", e(1, 0, 0, 0, 0, 1, 1, 1));
    tick();
    chk("hold_b_setup", e(0, 1, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 1, 1); tick();
    chk("hold_b_run", e(0, 1, 1, 0, 0, 0, 0, 0));
    tick();
    chk("hold_b_done", e(0, 1, 0, 1, 0, 0, 0, 1));
    drive(0, 0, 0, 0, 0, 0, 0); tick();

    // reset in the middle of a run discards the count and suppresses done
    drive(1, 1, 0, 10, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 1); tick();
    tick(); tick(); tick();
    chk("pre_rst_cnt3", e(0, 1, 1, 0, 0, 1, 0, 3));
    rst = 1'b1; tick();
    chk("mid_run_rst", e(1, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0; drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("post_rst_no_done", e(1, 0, 0, 0, 0, 0, 0, 0));

    // randomized commands against a timeline model: cycle 1 after accept is
    // settling, later cycles route until length reached or abort taken
    for (int n = 0; n < 60; n++) begin
      m_in  = 1'($urandom_range(0, 1));
      m_out = 1'($urandom_range(0, 1));
      rlen  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      ap    = $urandom_range(0, 3);
      m_cnt = '0;
      m_ab  = 1'b0;
      fin   = 1'b0;
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        tick();
      end
      drive(1, m_in, m_out, rlen, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      chk("rnd_setup", e(0, 1, 0, 0, 0, m_in, m_out, 0));
      c = 1;
      while (!fin && c < 400) begin
        mv = ($urandom_range(0, 3) != 0);
        mr = 1'($urandom_range(0, 1));
        ab = (ap != 0) && ($urandom_range(0, 15) < ap);
        drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), ab, mv, mr);
        if (c == 1) begin
          if (rlen == 0) fin = 1'b1;
        end else begin
          if (mv && mr) m_cnt = m_cnt + 16'd1;
          if (mv && mr && m_cnt == rlen) begin
            fin = 1'b1; m_ab = 1'b0;
          end else if (ab) begin
            fin = 1'b1; m_ab = 1'b1;
          end
        end
        tick();
        c++;
        if (fin) chk("rnd_done", e(0, 1, 0, 1, m_ab, m_in, m_out, m_cnt));
        else     chk("rnd_run",  e(0, 1, 1, 0, 0, m_in, m_out, m_cnt));
      end
      if (!fin) begin
        n_vec++;
        n_bad++;
        $display("FAIL rnd_timeout: command %0d still running after %0d cycles, want done", n, c);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("rnd_idle", e(1, 0, 0, 0, 0, m_in, m_out, m_cnt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
